// File: rtl/uart_frame_tx.sv
// uart_frame_tx: snapshots NUM_CH words on a trigger strobe and streams them to a byte
// transmitter as one frame: sync byte, payload bytes (ch0 first, each word MSB-first),
// and, when UART_FRAME_CHKSUM_EN is defined, a modulo-256 checksum of the payload.
// Drops triggers that arrive while a frame is in progress and counts them (saturating).

module uart_frame_tx #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_CH    = 2,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     handle,
    input  logic [NUM_CH*DATA_W-1:0] data,
    output logic [7:0]               tx_data,
    output logic                     tx_data_valid,
    input  logic                     tx_data_ready,
    output logic                     busy,
    output logic                     frame_done,
    output logic [7:0]               overrun_cnt
);

    localparam int BPC  = DATA_W / 8;        // bytes per channel word
    localparam int NB   = NUM_CH * BPC;      // payload bytes per frame
    localparam int IDXW = $clog2(NB + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;
`ifdef UART_FRAME_CHKSUM_EN
    localparam logic [1:0] ST_CHK  = 2'd3;
`endif

    logic [1:0]               state_q, state_d;
    logic [IDXW-1:0]          idx_q, idx_d;
    logic [IDXW-1:0]          sel_idx;
    logic [NUM_CH*DATA_W-1:0] shadow_q, shadow_d;
    logic [7:0]               tx_data_q, tx_data_d;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;
    logic [7:0]               ovr_q, ovr_d;
    logic [7:0]               pay_bytes [NB];
    logic [7:0]               pay_sel;
    logic                     accept;
`ifdef UART_FRAME_CHKSUM_EN
    logic [7:0]               chk_q, chk_d;
`endif

    // Reorder the shadow word into transmit order: channel ascending, byte MSB-first.
    always_comb begin
        for (int k = 0; k < NB; k++) begin
            pay_bytes[k] = shadow_q[(k / BPC) * DATA_W + (BPC - 1 - k % BPC) * 8 +: 8];
        end
    end

    // Select the payload byte to present next: byte 0 after the sync, else the one after idx.
    always_comb begin
        sel_idx = (state_q == ST_PAY) ? idx_q + 1'b1 : idx_q;
        pay_sel = 8'h00;
        for (int k = 0; k < NB; k++) begin
            if (sel_idx == IDXW'(k)) pay_sel = pay_bytes[k];
        end
    end

    assign accept = valid_q & tx_data_ready;

    // Frame sequencing, byte presentation and overrun counting.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        tx_data_d = tx_data_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        ovr_d     = ovr_q;
`ifdef UART_FRAME_CHKSUM_EN
        chk_d     = chk_q;
`endif

        if (handle && busy && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;

        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (handle) begin
                    state_d   = ST_HDR;
                    shadow_d  = data;
                    tx_data_d = SYNC_BYTE;
                    valid_d   = 1'b1;
`ifdef UART_FRAME_CHKSUM_EN
                    chk_d     = 8'h00;
`endif
                end
            end
            ST_HDR: begin
                if (accept) begin
                    state_d   = ST_PAY;
                    tx_data_d = pay_sel;
                end
            end
            ST_PAY: begin
                if (accept) begin
                    idx_d = idx_q + 1'b1;
`ifdef UART_FRAME_CHKSUM_EN
                    chk_d = chk_q + tx_data_q;
`endif
                    if (idx_q == IDXW'(NB - 1)) begin
`ifdef UART_FRAME_CHKSUM_EN
                        state_d   = ST_CHK;
                        tx_data_d = chk_q + tx_data_q;
`else
                        state_d   = ST_IDLE;
                        valid_d   = 1'b0;
                        done_d    = 1'b1;
`endif
                    end else begin
                        tx_data_d = pay_sel;
                    end
                end
            end
`ifdef UART_FRAME_CHKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            shadow_q  <= '0;
            tx_data_q <= 8'h00;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 8'h00;
`ifdef UART_FRAME_CHKSUM_EN
            chk_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            tx_data_q <= tx_data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
`ifdef UART_FRAME_CHKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_data_valid = valid_q;
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = done_q;
    assign overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Testbench for uart_frame_tx: default instance (16-bit x 2) plus a 24-bit x 1 instance.
// Expected frames come from a byte-list model built from the frame format rules.

module tb_uart_frame_tx;

`ifdef UART_FRAME_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        handle = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [7:0]  overrun_cnt;

    logic        handle_w = 1'b0;
    logic [23:0] data_w = '0;
    logic [7:0]  tx_data_w;
    logic        tx_valid_w;
    logic        ready_w = 1'b0;
    logic        busy_w;
    logic        done_w;
    logic [7:0]  ovr_w;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    uart_frame_tx u_dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .handle        (handle),
        .data          (data),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun_cnt   (overrun_cnt)
    );

    uart_frame_tx #(
        .DATA_W    (24),
        .NUM_CH    (1),
        .SYNC_BYTE (8'hA5)
    ) u_dut_w (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .handle        (handle_w),
        .data          (data_w),
        .tx_data       (tx_data_w),
        .tx_data_valid (tx_valid_w),
        .tx_data_ready (ready_w),
        .busy          (busy_w),
        .frame_done    (done_w),
        .overrun_cnt   (ovr_w)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference frame: sync, then each channel word split into bytes high to low, then sum.
    function automatic void model_frame(input logic [255:0] d, input int dw, input int nch);
        int sum;
        logic [7:0] byt;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        sum = 0;
        for (int k = 0; k < nch; k++) begin
            for (int b = dw / 8 - 1; b >= 0; b--) begin
                byt = 8'((d >> (k * dw + 8 * b)) & 256'hFF);
                exp_q.push_back(byt);
                sum = sum + int'(byt);
            end
        end
        if (CHK) exp_q.push_back(8'(sum % 256));
    endfunction

    task automatic pulse(input bit wide);
        if (wide) handle_w = 1'b1; else handle = 1'b1;
        @(posedge sys_clk); #1;
        handle_w = 1'b0;
        handle   = 1'b0;
    endtask

    // Drive ready (random duty) and record accepted bytes until frame_done or budget runs out.
    task automatic run_frame(input bit wide, input int unsigned rdy_pct,
                             output int cycles, output int busy_cyc, output bit timeout);
        logic r, v, bz;
        logic [7:0] d;
        got_q.delete();
        cycles = 0;
        busy_cyc = 0;
        timeout = 1'b0;
        forever begin
            r = ($urandom_range(99) < rdy_pct);
            if (wide) begin
                ready_w = r; v = tx_valid_w; d = tx_data_w; bz = busy_w;
            end else begin
                tx_data_ready = r; v = tx_data_valid; d = tx_data; bz = busy;
            end
            if (bz) busy_cyc++;
            @(posedge sys_clk); #1;
            cycles++;
            if (v && r) got_q.push_back(d);
            if (wide ? done_w : frame_done) break;
            if (cycles >= 2000) begin timeout = 1'b1; break; end
        end
        tx_data_ready = 1'b0;
        ready_w = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        cmp_cnt++; if (tx_data !== 8'h00) begin err_cnt++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        cmp_cnt++; if (tx_data_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %b want 0", tx_data_valid); end
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
        cmp_cnt++; if (frame_done !== 1'b0) begin err_cnt++; $display("FAIL rst_done: got %b want 0", frame_done); end
        cmp_cnt++; if (overrun_cnt !== 8'h00) begin err_cnt++; $display("FAIL rst_ovr: got %h want 00", overrun_cnt); end
        rst_n = 1'b1;
        @(posedge sys_clk); #1;
    endtask

    task automatic test_plan_frame;
        int cyc, bcyc, len;
        bit to;
        data = {16'hABCD, 16'h1234};
        model_frame(256'(data), 16, 2);
        len = exp_q.size();
        pulse(1'b0);
        run_frame(1'b0, 100, cyc, bcyc, to);
        cmp_cnt++; if (to) begin err_cnt++; $display("FAIL plan_timeout: got timeout want frame_done"); end
        cmp_cnt++; if (got_q.size() != len) begin err_cnt++; $display("FAIL plan_len: got %0d want %0d", got_q.size(), len); end
        for (int i = 0; i < len && i < got_q.size(); i++) begin
            cmp_cnt++;
            if (got_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL plan_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        cmp_cnt++; if (cyc != len) begin err_cnt++; $display("FAIL plan_cycles: got %0d want %0d", cyc, len); end
        cmp_cnt++; if (bcyc != len) begin err_cnt++; $display("FAIL plan_busy_cycles: got %0d want %0d", bcyc, len); end
        cmp_cnt++; if (tx_data_valid !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL plan_end: got valid=%b busy=%b want 0 0", tx_data_valid, busy); end
        @(posedge sys_clk); #1;
        cmp_cnt++; if (frame_done !== 1'b0) begin err_cnt++; $display("FAIL plan_done_width: got %b want 0", frame_done); end
    endtask

    task automatic test_random_frames;
        int cyc, bcyc;
        bit to;
        for (int n = 0; n < 20; n++) begin
            data = $urandom;
            model_frame(256'(data), 16, 2);
            pulse(1'b0);
            data = $urandom;
            run_frame(1'b0, $urandom_range(100, 30), cyc, bcyc, to);
            cmp_cnt++;
            if (to || got_q.size() != exp_q.size()) begin
                err_cnt++; $display("FAIL rand%0d_len: got %0d (timeout=%0b) want %0d", n, got_q.size(), to, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                cmp_cnt++;
                if (got_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL rand%0d_byte%0d: got %h want %h", n, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_backpressure;
        int cyc, bcyc;
        bit to;
        data = {16'hABCD, 16'h1234};
        model_frame(256'(data), 16, 2);
        pulse(1'b0);
        tx_data_ready = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        tx_data_ready = 1'b0;
        data = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge sys_clk); #1;
            cmp_cnt++;
            if (tx_data !== 8'h34 || tx_data_valid !== 1'b1) begin
                err_cnt++; $display("FAIL stall%0d: got data=%h valid=%b want 34 1", c, tx_data, tx_data_valid);
            end
        end
        run_frame(1'b0, 100, cyc, bcyc, to);
        cmp_cnt++;
        if (to || got_q.size() != exp_q.size() - 2) begin
            err_cnt++; $display("FAIL bp_tail_len: got %0d want %0d", got_q.size(), exp_q.size() - 2);
        end
        for (int i = 0; i < got_q.size() && i + 2 < exp_q.size(); i++) begin
            cmp_cnt++;
            if (got_q[i] !== exp_q[i + 2]) begin err_cnt++; $display("FAIL bp_byte%0d: got %h want %h", i + 2, got_q[i], exp_q[i + 2]); end
        end
    endtask

    task automatic test_done_trigger;
        int cyc, bcyc;
        bit to;
        logic [31:0] d2;
        data = $urandom;
        pulse(1'b0);
        run_frame(1'b0, 100, cyc, bcyc, to);
        cmp_cnt++; if (to || frame_done !== 1'b1) begin err_cnt++; $display("FAIL dt_first_done: got %b want 1", frame_done); end
        d2 = $urandom;
        data = d2;
        model_frame(256'(d2), 16, 2);
        pulse(1'b0);
        cmp_cnt++;
        if (tx_data_valid !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
            err_cnt++; $display("FAIL dt_start: got valid=%b data=%h busy=%b want 1 a5 1", tx_data_valid, tx_data, busy);
        end
        cmp_cnt++; if (overrun_cnt !== 8'h00) begin err_cnt++; $display("FAIL dt_ovr: got %0d want 0", overrun_cnt); end
        run_frame(1'b0, 100, cyc, bcyc, to);
        cmp_cnt++;
        if (to || got_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL dt_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            cmp_cnt++;
            if (got_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL dt_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int cyc, bcyc, vcnt;
        bit to;
        data = {16'hABCD, 16'h1234};
        pulse(1'b0);
        tx_data_ready = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        rst_n = 1'b0;
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        tx_data_ready = 1'b0;
        cmp_cnt++;
        if (tx_data !== 8'h00 || tx_data_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || overrun_cnt !== 8'h00) begin
            err_cnt++;
            $display("FAIL rm_reset: got data=%h valid=%b busy=%b done=%b ovr=%h want 00 0 0 0 00",
                     tx_data, tx_data_valid, busy, frame_done, overrun_cnt);
        end
        tx_data_ready = 1'b1;
        vcnt = 0;
        repeat (4) begin
            @(posedge sys_clk); #1;
            if (tx_data_valid || busy) vcnt++;
        end
        tx_data_ready = 1'b0;
        cmp_cnt++; if (vcnt != 0) begin err_cnt++; $display("FAIL rm_no_resume: got %0d active cycles want 0", vcnt); end
        data = $urandom;
        model_frame(256'(data), 16, 2);
        pulse(1'b0);
        run_frame(1'b0, 70, cyc, bcyc, to);
        cmp_cnt++;
        if (to || got_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL rm_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            cmp_cnt++;
            if (got_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL rm_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overrun;
        int cyc, bcyc, vcnt;
        bit to;
        rst_n = 1'b0;
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        data = $urandom;
        model_frame(256'(data), 16, 2);
        pulse(1'b0);
        for (int p = 0; p < 3; p++) begin
            pulse(1'b0);
            @(posedge sys_clk); #1;
        end
        cmp_cnt++; if (overrun_cnt !== 8'd3) begin err_cnt++; $display("FAIL ovr_3: got %0d want 3", overrun_cnt); end
        for (int p = 0; p < 300; p++) begin
            pulse(1'b0);
            if (p[0]) data = $urandom;
        end
        cmp_cnt++; if (overrun_cnt !== 8'd255) begin err_cnt++; $display("FAIL ovr_sat: got %0d want 255", overrun_cnt); end
        run_frame(1'b0, 100, cyc, bcyc, to);
        cmp_cnt++;
        if (to || got_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL ovr_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            cmp_cnt++;
            if (got_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL ovr_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        tx_data_ready = 1'b1;
        vcnt = 0;
        repeat (6) begin
            @(posedge sys_clk); #1;
            if (tx_data_valid) vcnt++;
        end
        tx_data_ready = 1'b0;
        cmp_cnt++; if (vcnt != 0) begin err_cnt++; $display("FAIL ovr_one_frame: got %0d extra valid cycles want 0", vcnt); end
        cmp_cnt++; if (overrun_cnt !== 8'd255) begin err_cnt++; $display("FAIL ovr_hold: got %0d want 255", overrun_cnt); end
    endtask

    task automatic test_wide;
        int cyc, bcyc;
        bit to;
        for (int n = 0; n < 4; n++) begin
            data_w = (n == 0) ? 24'hC0FFEE : 24'($urandom);
            model_frame(256'(data_w), 24, 1);
            pulse(1'b1);
            run_frame(1'b1, (n == 0) ? 100 : 60, cyc, bcyc, to);
            cmp_cnt++;
            if (to || got_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL wide%0d_len: got %0d want %0d", n, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                cmp_cnt++;
                if (got_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL wide%0d_byte%0d: got %h want %h", n, i, got_q[i], exp_q[i]); end
            end
        end
        cmp_cnt++; if (ovr_w !== 8'd0) begin err_cnt++; $display("FAIL wide_ovr: got %0d want 0", ovr_w); end
    endtask

    initial begin
        test_reset();
        test_plan_frame();
        test_random_frames();
        test_backpressure();
        test_done_trigger();
        test_reset_mid();
        test_overrun();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
